// File: rtl/fibre_encoder.sv
// Dense-to-compressed fibre encoder: builds a bitmask and LSB-first packed nonzero values, one fibre per handshake.
// Optional feature macro: FIBRE_ENC_DROP_EMPTY_EN (discard all-zero fibres and pulse fibre_dropped).
module fibre_encoder #(
  parameter int BITMASK_WIDTH = 8,
  parameter int WEIGHT_WIDTH  = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [WEIGHT_WIDTH-1:0]                in_data,
  input  logic                                   in_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [BITMASK_WIDTH-1:0]               out_bitmask,
  output logic [BITMASK_WIDTH*WEIGHT_WIDTH-1:0]  out_data,
  output logic [$clog2(BITMASK_WIDTH+1)-1:0]     out_count,
  output logic                                   fibre_dropped
);

  localparam int IW = $clog2(BITMASK_WIDTH);
  localparam int CW = $clog2(BITMASK_WIDTH+1);
  localparam int DW = BITMASK_WIDTH*WEIGHT_WIDTH;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] EMIT    = 2'd2;

  logic [1:0]               state_q;
  logic [IW-1:0]            idx_q;
  logic [CW-1:0]            count_q;
  logic [BITMASK_WIDTH-1:0] mask_acc_q;
  logic [DW-1:0]            data_acc_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic [BITMASK_WIDTH-1:0] out_bitmask_q;
  logic [DW-1:0]            out_data_q;
  logic [CW-1:0]            out_count_q;
  logic                     fibre_dropped_q;

  logic                     accept;
  logic                     nonzero;
  logic                     close_fibre;
  logic                     drop_empty;
  logic [CW-1:0]            count_d;
  logic [BITMASK_WIDTH-1:0] mask_d;
  logic [DW-1:0]            data_d;

  assign accept      = in_valid && in_ready_q;
  assign nonzero     = |in_data;
  assign close_fibre = accept && (in_last || (idx_q == IW'(BITMASK_WIDTH-1)));
  assign count_d     = count_q + CW'(nonzero);

`ifdef FIBRE_ENC_DROP_EMPTY_EN
  assign drop_empty = (count_d == '0);
`else
  assign drop_empty = 1'b0;
`endif

  // Accumulator view including the element presented this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < BITMASK_WIDTH; gi++) begin : g_slot
      assign mask_d[gi] = mask_acc_q[gi] | (nonzero && (idx_q == IW'(gi)));
      assign data_d[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
        (nonzero && (count_q == CW'(gi))) ? in_data
                                          : data_acc_q[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      count_q         <= '0;
      mask_acc_q      <= '0;
      data_acc_q      <= '0;
      in_ready_q      <= 1'b0;
      out_valid_q     <= 1'b0;
      out_bitmask_q   <= '0;
      out_data_q      <= '0;
      out_count_q     <= '0;
      fibre_dropped_q <= 1'b0;
    end else begin
      fibre_dropped_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q    <= COLLECT;
          in_ready_q <= 1'b1;
        end
        COLLECT: begin
          if (close_fibre) begin
            idx_q      <= '0;
            count_q    <= '0;
            mask_acc_q <= '0;
            data_acc_q <= '0;
            if (drop_empty) begin
              fibre_dropped_q <= 1'b1;
            end else begin
              state_q       <= EMIT;
              in_ready_q    <= 1'b0;
              out_valid_q   <= 1'b1;
              out_bitmask_q <= mask_d;
              out_data_q    <= data_d;
              out_count_q   <= count_d;
            end
          end else if (accept) begin
            idx_q      <= idx_q + IW'(1);
            count_q    <= count_d;
            mask_acc_q <= mask_d;
            data_acc_q <= data_d;
          end
        end
        EMIT: begin
          if (out_ready) begin
            state_q     <= COLLECT;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_bitmask   = out_bitmask_q;
  assign out_data      = out_data_q;
  assign out_count     = out_count_q;
  assign fibre_dropped = fibre_dropped_q;

endmodule

// File: tb/tb_fibre_encoder.sv
// Testbench for fibre_encoder: directed test-plan fibres plus randomized fibres against a packing model.
module tb_fibre_encoder;
  localparam int BW = 8;
  localparam int WW = 8;
  localparam int CW = $clog2(BW+1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WW-1:0]     in_data = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [BW-1:0]     out_bitmask;
  logic [BW*WW-1:0]  out_data;
  logic [CW-1:0]     out_count;
  logic              fibre_dropped;

  fibre_encoder #(.BITMASK_WIDTH(BW), .WEIGHT_WIDTH(WW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bitmask(out_bitmask), .out_data(out_data), .out_count(out_count),
    .fibre_dropped(fibre_dropped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int fibre_no = 0;

  logic [WW-1:0] fv[BW];
  int            fg[BW];
  int            flen;
  bit            flast;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one element after `gap` idle cycles; returns once it has been accepted.
  task automatic push(input logic [WW-1:0] v, input bit last, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = WW'($urandom);
      in_last  = 1'(($urandom & 1));
      tick();
    end
    in_valid = 1'b1;
    in_data  = v;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("accept_timeout", 64'd0, 64'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = WW'($urandom);
  endtask

  task automatic run_fibre(input int hold);
    logic [BW-1:0]    em;
    logic [BW*WW-1:0] ed;
    int               k;
    em = '0;
    ed = '0;
    k  = 0;
    for (int i = 0; i < flen; i++) begin
      if (fv[i] != 0) begin
        em[i] = 1'b1;
        ed[k*WW +: WW] = fv[i];
        k++;
      end
    end
    for (int i = 0; i < flen; i++)
      push(fv[i], (i == flen-1) && (flen < BW || flast), fg[i]);
    fibre_no++;
`ifdef FIBRE_ENC_DROP_EMPTY_EN
    if (k == 0) begin
      check("drop_pulse", 64'(fibre_dropped), 64'd1);
      check("drop_no_valid", 64'(out_valid), 64'd0);
      check("drop_in_ready", 64'(in_ready), 64'd1);
      tick();
      check("drop_pulse_end", 64'(fibre_dropped), 64'd0);
      $display("fibre %0d len=%0d dropped", fibre_no, flen);
      return;
    end
`endif
    check("out_valid", 64'(out_valid), 64'd1);
    check("in_ready_emit", 64'(in_ready), 64'd0);
    check("bitmask", 64'(out_bitmask), 64'(em));
    check("data", 64'(out_data), 64'(ed));
    check("count", 64'(out_count), 64'(k));
    check("no_drop", 64'(fibre_dropped), 64'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_bitmask", 64'(out_bitmask), 64'(em));
      check("hold_data", 64'(out_data), 64'(ed));
      check("hold_count", 64'(out_count), 64'(k));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_valid", 64'(out_valid), 64'd0);
    check("post_in_ready", 64'(in_ready), 64'd1);
    $display("fibre %0d len=%0d mask=%b count=%0d data=%h", fibre_no, flen, em, k, ed);
  endtask

  task automatic set_fibre(input logic [63:0] vals, input int len, input bit last, input int gap);
    for (int i = 0; i < BW; i++) begin
      fv[i] = vals[i*WW +: WW];
      fg[i] = gap;
    end
    flen  = len;
    flast = last;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_bitmask", 64'(out_bitmask), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_count", 64'(out_count), 64'd0);
    check("rst_drop", 64'(fibre_dropped), 64'd0);
    rst = 1'b1;
    check("release_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("first_in_ready", 64'(in_ready), 64'd1);

    // Slots listed idx0 in the low byte.
    set_fibre(64'h08_00_06_00_04_00_02_00, 8, 1'b0, 0); run_fibre(0);
    set_fibre(64'h00_00_00_00_00_07_00_05, 3, 1'b1, 0); run_fibre(0);
    set_fibre(64'h0, 8, 1'b0, 0);                       run_fibre(0);
    set_fibre(64'h08_07_06_05_04_03_02_01, 8, 1'b1, 0); run_fibre(5);
    set_fibre(64'h00_00_00_00_00_09_00_03, 3, 1'b1, 2); run_fibre(1);

    // Reset mid-fibre while the previous fibre's outputs are still held nonzero.
    push(8'h11, 1'b0, 0);
    push(8'h22, 1'b0, 0);
    push(8'h33, 1'b0, 0);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_bitmask", 64'(out_bitmask), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    check("mid_rst_count", 64'(out_count), 64'd0);
    tick();
    rst = 1'b1;
    set_fibre(64'h02_00_00_00_00_00_00_01, 8, 1'b0, 0); run_fibre(0);

    // Randomized fibres.
    for (int r = 0; r < 60; r++) begin
      flen  = $urandom_range(1, BW);
      flast = 1'($urandom_range(0, 1));
      for (int i = 0; i < BW; i++) begin
        fv[i] = ($urandom_range(0, 2) == 0) ? '0 : WW'($urandom_range(1, 255));
        fg[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      end
      if (r % 10 == 9) for (int i = 0; i < BW; i++) fv[i] = '0;
      run_fibre($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
